// File: rtl/ras_pkg.sv
// Shared geometry, widths and checkpoint snapshot type for the return address stack.
// Reconfigure the stack and checkpoint ring by editing the localparams here.
package ras_pkg;
   localparam int WIDTH     = 32;
   localparam int DEPTH     = 16;
   localparam int ADDR      = 4;
   localparam int CKPTS     = 8;
   localparam int CKPT_ADDR = 3;

   localparam int CNT_W = ADDR + 1;
   localparam int TAG_W = CKPT_ADDR;
   localparam int OCC_W = CKPT_ADDR + 1;

   typedef struct packed {
      logic [ADDR-1:0]  tosp;
      logic [CNT_W-1:0] count;
      logic [WIDTH-1:0] top;
   } ras_ckpt_t;

   // Age of a tag relative to the ring head, mod CKPTS.
   function automatic logic [TAG_W-1:0] tag_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
      return tag - head;
   endfunction
endpackage

// File: rtl/ras_ckpt_ring.sv
// Checkpoint ring: allocate at tail, retire at head, restore by tag; snapshot readable one cycle after allocation.
// No backpressure beyond ckpt_ready; a request while full or a restore of a dead tag raises ckpt_err next cycle.
module ras_ckpt_ring
   import ras_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             ckpt_req,
   input  ras_ckpt_t        snap,
   input  logic             restore,
   input  logic [TAG_W-1:0] restore_tag,
   input  logic             commit,
   output logic             ckpt_ready,
   output logic [TAG_W-1:0] ckpt_tag,
   output logic             ckpt_err,
   output logic             rst_ok,
   output ras_ckpt_t        rst_snap
);
   ras_ckpt_t        slot_q [CKPTS];
   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             err_q, err_d;

   logic             commit_ok, live, slot_we;
   logic [TAG_W-1:0] head_c, age;
   logic [OCC_W-1:0] occ_c;

   assign ckpt_ready = (occ_q < OCC_W'(CKPTS));
   assign ckpt_tag   = tail_q;
   assign ckpt_err   = err_q;
   assign rst_snap   = slot_q[restore_tag];
   assign rst_ok     = restore && live;

   // Commit is applied first so a restore sees the post-commit live set.
   always_comb begin
      commit_ok = commit && (occ_q != '0);
      head_c    = head_q + TAG_W'(commit_ok);
      occ_c     = occ_q - OCC_W'(commit_ok);
      age       = tag_age(restore_tag, head_c);
      live      = ({1'b0, age} < occ_c);
      head_d    = head_c;
      tail_d    = tail_q;
      occ_d     = occ_c;
      err_d     = 1'b0;
      slot_we   = 1'b0;
      if (restore) begin
         if (live) begin
            tail_d = restore_tag;
            occ_d  = {1'b0, age};
         end else begin
            err_d = 1'b1;
         end
      end else if (ckpt_req) begin
         if (ckpt_ready) begin
            slot_we = 1'b1;
            tail_d  = tail_q + 1'b1;
            occ_d   = occ_c + 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (slot_we) slot_q[tail_q] <= snap;
   end
endmodule

// File: rtl/ras_ckpt.sv
// Circular return address stack with tagged checkpoints; dout is the flopped top, restores visible next cycle.
// No backpressure: overflow overwrites the oldest entry; overflow/underflow pulse the cycle after. RAS_STATS_EN adds counters.
module ras_ckpt
   import ras_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   input  logic             ckpt_req,
   output logic             ckpt_ready,
   output logic [TAG_W-1:0] ckpt_tag,
   input  logic             restore,
   input  logic [TAG_W-1:0] restore_tag,
   input  logic             commit,
   output logic             ckpt_err
`ifdef RAS_STATS_EN
   ,
   output logic [15:0]      stat_ovf,
   output logic [15:0]      stat_unf,
   output logic [15:0]      stat_rst
`endif
);
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [ADDR-1:0]  tosp_q, tosp_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;

   logic             we;
   logic [ADDR-1:0]  waddr;
   logic [WIDTH-1:0] wdata;
   logic             rst_ok;
   ras_ckpt_t        snap, rst_snap;

   assign dout      = stack_q[tosp_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign overflow  = ovf_q;
   assign underflow = unf_q;

   always_comb begin
      tosp_d  = tosp_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      we      = 1'b0;
      waddr   = tosp_q;
      wdata   = din;
      if (restore) begin
         if (rst_ok) begin
            tosp_d  = rst_snap.tosp;
            count_d = rst_snap.count;
            if (rst_snap.count != '0) begin
               we    = 1'b1;
               waddr = rst_snap.tosp;
               wdata = rst_snap.top;
            end
         end
      end else if (push && (!pop || empty)) begin
         we      = 1'b1;
         waddr   = tosp_q + 1'b1;
         tosp_d  = tosp_q + 1'b1;
         count_d = full ? count_q : count_q + 1'b1;
         ovf_d   = full;
      end else if (push && pop) begin
         we = 1'b1;
      end else if (pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            tosp_d  = tosp_q - 1'b1;
            count_d = count_q - 1'b1;
         end
      end
   end

   // Snapshot reflects this cycle's post-push/pop state; a pushed value bypasses the array.
   always_comb begin
      snap.tosp  = tosp_d;
      snap.count = count_d;
      snap.top   = push ? din : stack_q[tosp_d];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tosp_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tosp_q  <= tosp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) stack_q[waddr] <= wdata;
   end

   ras_ckpt_ring u_ring (
      .clk         (clk),
      .reset       (reset),
      .ckpt_req    (ckpt_req),
      .snap        (snap),
      .restore     (restore),
      .restore_tag (restore_tag),
      .commit      (commit),
      .ckpt_ready  (ckpt_ready),
      .ckpt_tag    (ckpt_tag),
      .ckpt_err    (ckpt_err),
      .rst_ok      (rst_ok),
      .rst_snap    (rst_snap)
   );

`ifdef RAS_STATS_EN
   logic [15:0] stat_ovf_q, stat_ovf_d, stat_unf_q, stat_unf_d, stat_rst_q, stat_rst_d;

   always_comb begin
      stat_ovf_d = stat_ovf_q + 16'((ovf_d  && (stat_ovf_q != '1)) ? 1 : 0);
      stat_unf_d = stat_unf_q + 16'((unf_d  && (stat_unf_q != '1)) ? 1 : 0);
      stat_rst_d = stat_rst_q + 16'((rst_ok && (stat_rst_q != '1)) ? 1 : 0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_ovf_q <= '0;
         stat_unf_q <= '0;
         stat_rst_q <= '0;
      end else begin
         stat_ovf_q <= stat_ovf_d;
         stat_unf_q <= stat_unf_d;
         stat_rst_q <= stat_rst_d;
      end
   end

   assign stat_ovf = stat_ovf_q;
   assign stat_unf = stat_unf_q;
   assign stat_rst = stat_rst_q;
`endif
endmodule
